// File: rtl/generador_frec_pkg.sv
// Shared definitions for the NCO test-signal generator: state encoding,
// default widths and the increment clamp for the default accumulator width.
package generador_frec_pkg;

    localparam int ACC_WIDTH_DEF = 32;
    localparam int CNT_WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } estado_t;

    // Largest useful increment: half a turn per cycle, i.e. f_clock/2.
    localparam logic [ACC_WIDTH_DEF-1:0] INC_MAX_DEF = {1'b1, {(ACC_WIDTH_DEF-1){1'b0}}};

endpackage

// File: rtl/generador_frec_if.sv
// Configuration handshake bundle between a controller (master) and the
// generator (slave).
interface generador_frec_if
    import generador_frec_pkg::*;
#(
    parameter int ACC_WIDTH = ACC_WIDTH_DEF,
    parameter int CNT_WIDTH = CNT_WIDTH_DEF
);
    logic                 cfg_valid;
    logic                 cfg_ready;
    logic [ACC_WIDTH-1:0] cfg_inc;
    logic [CNT_WIDTH-1:0] cfg_burst;

    modport master (
        output cfg_valid,
        output cfg_inc,
        output cfg_burst,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_inc,
        input  cfg_burst,
        output cfg_ready
    );
endinterface

// File: rtl/generador_frec_acumulador_fase.sv
// Phase accumulator: holds the latched increment and the running phase,
// and exposes the MSB the phase will have after the next add.
module acumulador_fase #(
    parameter int ACC_WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 load,
    input  logic                 clr,
    input  logic                 add,
    input  logic [ACC_WIDTH-1:0] inc_in,
    output logic                 msb_next
);
    logic [ACC_WIDTH-1:0] acc_reg;
    logic [ACC_WIDTH-1:0] inc_reg;
    logic [ACC_WIDTH-1:0] acc_next;

    assign acc_next = acc_reg + inc_reg;
    assign msb_next = acc_next[ACC_WIDTH-1];

    // Load starts a fresh configuration: new increment, phase back to zero.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            acc_reg <= '0;
            inc_reg <= '0;
        end else if (load) begin
            acc_reg <= '0;
            inc_reg <= inc_in;
        end else if (clr) begin
            acc_reg <= '0;
        end else if (add) begin
            acc_reg <= acc_next;
        end
    end
endmodule

// File: rtl/generador_frec.sv
// NCO square-wave generator: continuous or N-edge burst output with a
// saturating count of emitted rising edges.
module generador_frec
    import generador_frec_pkg::*;
#(
    parameter int ACC_WIDTH = ACC_WIDTH_DEF,
    parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 enable,
    generador_frec_if.slave      cfg,
    output logic                 clock_g,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] edges
);
    localparam logic [ACC_WIDTH-1:0] INC_MAX = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    estado_t              state_reg;
    logic                 clock_g_reg;
    logic                 busy_reg;
    logic                 done_reg;
    logic [CNT_WIDTH-1:0] edges_reg;
    logic [CNT_WIDTH-1:0] burst_reg;

    logic                 cfg_ready_int;
    logic                 handshake;
    logic [ACC_WIDTH-1:0] inc_clamp;
    logic                 msb_next;
    logic                 rise;
    logic                 fall;
    logic                 burst_end;

    assign cfg_ready_int = (state_reg == IDLE) && enable && reset_n;
    assign cfg.cfg_ready = cfg_ready_int;
    assign handshake     = cfg.cfg_valid && cfg_ready_int;
    assign inc_clamp     = (cfg.cfg_inc > INC_MAX) ? INC_MAX : cfg.cfg_inc;

    acumulador_fase #(.ACC_WIDTH(ACC_WIDTH)) u_acc (
        .clock    (clock),
        .reset_n  (reset_n),
        .load     (handshake),
        .clr      (!enable),
        .add      ((state_reg == RUN) && enable),
        .inc_in   (inc_clamp),
        .msb_next (msb_next)
    );

    assign rise = !clock_g_reg && msb_next;
    assign fall = clock_g_reg && !msb_next;
    // Ending only on a falling edge guarantees the last pulse is complete.
    assign burst_end = (burst_reg != '0) && (edges_reg == burst_reg) && fall;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            clock_g_reg <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            edges_reg   <= '0;
            burst_reg   <= '0;
        end else begin
            busy_reg <= (state_reg == RUN);
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    clock_g_reg <= 1'b0;
                    if (handshake) begin
                        burst_reg <= cfg.cfg_burst;
                        edges_reg <= '0;
                        if (cfg.cfg_inc == '0) begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (!enable) begin
                        state_reg   <= IDLE;
                        clock_g_reg <= 1'b0;
                    end else begin
                        clock_g_reg <= msb_next;
                        if (rise && (edges_reg != '1)) begin
                            edges_reg <= edges_reg + 1'b1;
                        end
                        if (burst_end) begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_reg   <= IDLE;
                    clock_g_reg <= 1'b0;
                end
                default: begin
                    state_reg   <= IDLE;
                    clock_g_reg <= 1'b0;
                end
            endcase
        end
    end

    assign clock_g = clock_g_reg;
    assign busy    = busy_reg;
    assign done    = done_reg;
    assign edges   = edges_reg;
endmodule

// File: tb/tb_generador_frec.sv
// Self-checking bench for generador_frec: directed scenarios plus random
// configurations compared against a closed-form phase model.
module tb_generador_frec;
    localparam int ACC = 32;
    localparam int CNT = 6;
    localparam int unsigned EDGE_MAX = (1 << CNT) - 1;

    logic           clock = 1'b0;
    logic           reset_n;
    logic           enable;
    logic           clock_g;
    logic           busy;
    logic           done;
    logic [CNT-1:0] edges;

    generador_frec_if #(.ACC_WIDTH(ACC), .CNT_WIDTH(CNT)) cfg_if ();

    generador_frec #(.ACC_WIDTH(ACC), .CNT_WIDTH(CNT)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .enable  (enable),
        .cfg     (cfg_if.slave),
        .clock_g (clock_g),
        .busy    (busy),
        .done    (done),
        .edges   (edges)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;
    int unsigned exp_edges = 0;

    task automatic chequear(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One configuration: handshake, then follow the model cycle by cycle.
    // abort_n > 0 drops enable just before edge abort_n after the handshake.
    task automatic correr(input logic [ACC-1:0] inc, input int unsigned burst,
                          input int abort_n, input string nombre);
        logic [63:0] inc_c;
        logic [63:0] prod;
        bit          prev;
        bit          cg;
        bit          fin;
        inc_c = (inc > 32'h8000_0000) ? 64'h8000_0000 : 64'(inc);
        chequear({nombre, ".ready_idle"}, 64'(cfg_if.cfg_ready), 64'd1);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_inc   = inc;
        cfg_if.cfg_burst = CNT'(burst);
        tick();
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_inc   = $urandom;
        cfg_if.cfg_burst = CNT'($urandom);
        exp_edges = 0;
        fin = 1'b0;
        if (inc == '0) begin
            chequear({nombre, ".done"}, 64'(done), 64'd1);
            chequear({nombre, ".cg"}, 64'(clock_g), 64'd0);
            chequear({nombre, ".edges"}, 64'(edges), 64'd0);
            tick();
            chequear({nombre, ".done_end"}, 64'(done), 64'd0);
            chequear({nombre, ".ready_end"}, 64'(cfg_if.cfg_ready), 64'd1);
            chequear({nombre, ".cg_end"}, 64'(clock_g), 64'd0);
            fin = 1'b1;
        end
        prev = 1'b0;
        for (int n = 1; n <= 4000 && !fin; n++) begin
            if (n == abort_n) begin
                cfg_if.cfg_valid = 1'b0;
                enable = 1'b0;
            end else begin
                cfg_if.cfg_valid = 1'($urandom);
                cfg_if.cfg_inc   = $urandom;
            end
            tick();
            if (n == abort_n) begin
                chequear({nombre, ".abort_cg"}, 64'(clock_g), 64'd0);
                chequear({nombre, ".abort_done"}, 64'(done), 64'd0);
                chequear({nombre, ".abort_edges"}, 64'(edges), 64'(exp_edges));
                chequear({nombre, ".abort_ready"}, 64'(cfg_if.cfg_ready), 64'd0);
                enable = 1'b1;
                tick();
                chequear({nombre, ".abort_ready2"}, 64'(cfg_if.cfg_ready), 64'd1);
                chequear({nombre, ".abort_done2"}, 64'(done), 64'd0);
                chequear({nombre, ".abort_busy2"}, 64'(busy), 64'd0);
                chequear({nombre, ".abort_hold"}, 64'(edges), 64'(exp_edges));
                fin = 1'b1;
            end else begin
                prod = 64'(n) * inc_c;
                cg   = prod[ACC-1];
                if (cg && !prev && exp_edges != EDGE_MAX) exp_edges++;
                if (burst != 0 && prev && !cg && exp_edges == burst) begin
                    cfg_if.cfg_valid = 1'b0;
                    chequear({nombre, ".done"}, 64'(done), 64'd1);
                    chequear({nombre, ".cg_last"}, 64'(clock_g), 64'd0);
                    chequear({nombre, ".edges"}, 64'(edges), 64'(exp_edges));
                    tick();
                    chequear({nombre, ".done_end"}, 64'(done), 64'd0);
                    chequear({nombre, ".ready_end"}, 64'(cfg_if.cfg_ready), 64'd1);
                    chequear({nombre, ".busy_end"}, 64'(busy), 64'd0);
                    chequear({nombre, ".edges_hold"}, 64'(edges), 64'(exp_edges));
                    fin = 1'b1;
                end else begin
                    chequear({nombre, ".cg"}, 64'(clock_g), 64'(cg));
                    chequear({nombre, ".edges_run"}, 64'(edges), 64'(exp_edges));
                    chequear({nombre, ".done_run"}, 64'(done), 64'd0);
                    chequear({nombre, ".busy_run"}, 64'(busy), 64'd1);
                    chequear({nombre, ".ready_run"}, 64'(cfg_if.cfg_ready), 64'd0);
                end
                prev = cg;
            end
        end
        cfg_if.cfg_valid = 1'b0;
        chequear({nombre, ".terminated"}, 64'(fin), 64'd1);
        $display("%s inc=%08h burst=%0d abort=%0d edges=%0d", nombre, inc, burst, abort_n, edges);
    endtask

    initial begin
        int unsigned b;
        int          ab;
        logic [ACC-1:0] ri;

        reset_n          = 1'b0;
        enable           = 1'b1;
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_inc   = 32'h4000_0000;
        cfg_if.cfg_burst = CNT'(3);
        for (int i = 0; i < 3; i++) begin
            tick();
            chequear("reset.ready", 64'(cfg_if.cfg_ready), 64'd0);
            chequear("reset.cg", 64'(clock_g), 64'd0);
            chequear("reset.edges", 64'(edges), 64'd0);
            chequear("reset.busy", 64'(busy), 64'd0);
            chequear("reset.done", 64'(done), 64'd0);
        end
        cfg_if.cfg_valid = 1'b0;
        reset_n = 1'b1;
        tick();
        chequear("reset.no_handshake", 64'(busy), 64'd0);
        $display("reset held 3 cycles with cfg_valid=1");

        correr(32'h4000_0000, 3, 0, "burst");
        correr(32'hFFFF_FFFF, 5, 0, "clamp");
        correr(32'h0000_0000, 7, 0, "zero");
        correr(32'h1000_0000, 0, 100, "abort");
        chequear("abort.six_edges", 64'(edges), 64'd6);
        correr(32'h8000_0000, 0, 140, "saturate");
        correr(32'h0200_0000, 0, 300, "loopback");

        // Reset in the middle of a run: no done pulse, counters cleared.
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_inc   = 32'h1000_0000;
        cfg_if.cfg_burst = '0;
        tick();
        cfg_if.cfg_valid = 1'b0;
        repeat (30) tick();
        reset_n = 1'b0;
        tick();
        chequear("midreset.cg", 64'(clock_g), 64'd0);
        chequear("midreset.edges", 64'(edges), 64'd0);
        chequear("midreset.done", 64'(done), 64'd0);
        reset_n = 1'b1;
        tick();
        chequear("midreset.done2", 64'(done), 64'd0);
        chequear("midreset.ready", 64'(cfg_if.cfg_ready), 64'd1);
        $display("midreset inc=10000000 edges=%0d", edges);

        for (int t = 0; t < 20; t++) begin
            ri = ($urandom_range(7, 0) == 0) ? 32'h0 : $urandom_range(32'hFFFF_FFFF, 32'h0400_0000);
            b  = $urandom_range(6, 0);
            if (b == 0) ab = int'($urandom_range(150, 5));
            else        ab = ($urandom_range(3, 0) == 0) ? int'($urandom_range(80, 2)) : 0;
            correr(ri, b, ab, $sformatf("rnd%0d", t));
            repeat ($urandom_range(3, 0)) tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
